// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared SRAM port.
// The arbiter takes the slave view; requesters and the SRAM model take the master view.
interface sram_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Fetch/load-store arbiter for one single-port SRAM with 1-cycle read latency.
// Data side has priority; a saturating counter forces a fetch grant after STARVE_MAX data wins.
module sram_arbiter #(
  parameter int STARVE_MAX = 4  // must fit the 3-bit starvation counter (<= 7)
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  resp_t      resp_q, resp_next;
  logic [2:0] starve_cnt, starve_cnt_next;
  logic       grant_inst, grant_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q     <= RESP_NONE;
      starve_cnt <= 3'd0;
    end else begin
      resp_q     <= resp_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  always_comb begin
    grant_inst        = 1'b0;
    grant_data        = 1'b0;
    resp_next         = RESP_NONE;
    starve_cnt_next   = starve_cnt;
    bus.inst_addr_ok  = 1'b0;
    bus.data_addr_ok  = 1'b0;
    bus.inst_data_ok  = 1'b0;
    bus.inst_rdata    = 32'd0;
    bus.data_data_ok  = 1'b0;
    bus.data_rdata    = 32'd0;
    bus.sram_en       = 1'b0;
    bus.sram_wen      = 4'b0000;
    bus.sram_addr     = 32'd0;
    bus.sram_wdata    = 32'd0;

    // Grants are suppressed in reset so nothing reaches the SRAM
    if (!rst) begin
      if (bus.inst_req && (!bus.data_req || starve_cnt == STARVE_LIM)) begin
        grant_inst = 1'b1;
      end else if (bus.data_req) begin
        grant_data = 1'b1;
      end
    end

    if (grant_inst) begin
      resp_next        = RESP_INST;
      bus.inst_addr_ok = 1'b1;
      bus.sram_en      = 1'b1;
      bus.sram_addr    = bus.inst_addr;
    end else if (grant_data) begin
      resp_next        = RESP_DATA;
      bus.data_addr_ok = 1'b1;
      bus.sram_en      = 1'b1;
      bus.sram_wen     = bus.data_wen;
      bus.sram_addr    = bus.data_addr;
      bus.sram_wdata   = bus.data_wdata;
    end

    // Counts only data wins that actually held a fetch off
    if (!bus.inst_req || grant_inst) begin
      starve_cnt_next = 3'd0;
    end else if (grant_data && starve_cnt != STARVE_LIM) begin
      starve_cnt_next = starve_cnt + 3'd1;
    end

    // A response still owned when reset hits must not be reported
    if (!rst) begin
      case (resp_q)
        RESP_INST: begin
          bus.inst_data_ok = 1'b1;
          bus.inst_rdata   = bus.sram_rdata;
        end
        RESP_DATA: begin
          bus.data_data_ok = 1'b1;
          bus.data_rdata   = bus.sram_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a read-first SRAM model answers one cycle after sram_en.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_sram_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sram_arbiter_if bus ();

  sram_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word array indexed by addr[13:2], preloaded while rst is high
  logic [31:0] mem [0:4095];
  logic [31:0] wr_word;

  always @(posedge clk) begin
    if (rst) begin
      mem[12'h400] <= 32'h2402_0001;  // 0x0000_1000
      mem[12'h801] <= 32'h0102_0304;  // 0x0000_2004
      mem[12'hC00] <= 32'h1111_2222;  // 0x0000_3000
    end else if (bus.sram_en) begin
      bus.sram_rdata <= mem[bus.sram_addr[13:2]];
      wr_word = mem[bus.sram_addr[13:2]];
      for (int b = 0; b < 4; b++) begin
        if (bus.sram_wen[b]) wr_word[8*b +: 8] = bus.sram_wdata[8*b +: 8];
      end
      mem[bus.sram_addr[13:2]] <= wr_word;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req   = 1'b0;
    bus.inst_addr  = 32'd0;
    bus.data_req   = 1'b0;
    bus.data_wen   = 4'b0000;
    bus.data_addr  = 32'd0;
    bus.data_wdata = 32'd0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'h0000_1000;
    bus.data_req   = 1'b1;
    bus.data_addr  = 32'h0000_3000;
    bus.data_wen   = 4'b1111;
    bus.data_wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.inst_addr_ok !== 1'b0 || bus.data_addr_ok !== 1'b0) begin
        failures++;
        $display("FAIL reset_addr_ok cycle=%0d got inst=%b data=%b exp 0/0", c, bus.inst_addr_ok, bus.data_addr_ok);
      end
      checks++;
      if (bus.sram_en !== 1'b0 || bus.sram_wen !== 4'b0000) begin
        failures++;
        $display("FAIL reset_sram cycle=%0d got en=%b wen=%b exp 0/0000", c, bus.sram_en, bus.sram_wen);
      end
      checks++;
      if (bus.inst_data_ok !== 1'b0 || bus.data_data_ok !== 1'b0 ||
          bus.inst_rdata !== 32'd0 || bus.data_rdata !== 32'd0) begin
        failures++;
        $display("FAIL reset_resp cycle=%0d got ok=%b/%b rdata=%h/%h exp 0", c, bus.inst_data_ok,
                 bus.data_data_ok, bus.inst_rdata, bus.data_rdata);
      end
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.inst_data_ok !== 1'b0 || bus.data_data_ok !== 1'b0 || bus.sram_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ok=%b/%b en=%b exp 0/0/0", bus.inst_data_ok, bus.data_data_ok, bus.sram_en);
    end
    $display("txn reset: 3 cycles with both requests held, released idle");
    next_cycle();
  endtask

  task automatic test_single_fetch();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_1000;
    @(negedge clk);
    checks++;
    if (bus.inst_addr_ok !== 1'b1 || bus.data_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL fetch_addr_ok got inst=%b data=%b exp 1/0", bus.inst_addr_ok, bus.data_addr_ok);
    end
    checks++;
    if (bus.sram_en !== 1'b1 || bus.sram_addr !== 32'h0000_1000 ||
        bus.sram_wen !== 4'b0000 || bus.sram_wdata !== 32'd0) begin
      failures++;
      $display("FAIL fetch_sram got en=%b addr=%h wen=%b wdata=%h exp 1/00001000/0000/0", bus.sram_en,
               bus.sram_addr, bus.sram_wen, bus.sram_wdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== 32'h2402_0001) begin
      failures++;
      $display("FAIL fetch_data got ok=%b rdata=%h exp 1/24020001", bus.inst_data_ok, bus.inst_rdata);
    end
    checks++;
    if (bus.data_data_ok !== 1'b0 || bus.sram_en !== 1'b0) begin
      failures++;
      $display("FAIL fetch_idle got data_ok=%b en=%b exp 0/0", bus.data_data_ok, bus.sram_en);
    end
    $display("txn fetch addr=00001000 rdata=%h", bus.inst_rdata);
    next_cycle();
  endtask

  task automatic test_simultaneous();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_1000;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_3000;
    @(negedge clk);
    checks++;
    if (bus.data_addr_ok !== 1'b1 || bus.inst_addr_ok !== 1'b0 || bus.sram_addr !== 32'h0000_3000) begin
      failures++;
      $display("FAIL simul_first got d=%b i=%b addr=%h exp 1/0/00003000", bus.data_addr_ok,
               bus.inst_addr_ok, bus.sram_addr);
    end
    next_cycle();
    bus.data_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.inst_addr_ok !== 1'b1 || bus.data_addr_ok !== 1'b0 || bus.sram_addr !== 32'h0000_1000) begin
      failures++;
      $display("FAIL simul_second got i=%b d=%b addr=%h exp 1/0/00001000", bus.inst_addr_ok,
               bus.data_addr_ok, bus.sram_addr);
    end
    checks++;
    if (bus.data_data_ok !== 1'b1 || bus.data_rdata !== 32'h1111_2222 || bus.inst_data_ok !== 1'b0) begin
      failures++;
      $display("FAIL simul_data_resp got ok=%b rdata=%h iok=%b exp 1/11112222/0", bus.data_data_ok,
               bus.data_rdata, bus.inst_data_ok);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== 32'h2402_0001 || bus.data_data_ok !== 1'b0) begin
      failures++;
      $display("FAIL simul_inst_resp got ok=%b rdata=%h dok=%b exp 1/24020001/0", bus.inst_data_ok,
               bus.inst_rdata, bus.data_data_ok);
    end
    $display("txn simultaneous: data 00003000 then fetch 00001000");
    next_cycle();
  endtask

  task automatic test_store();
    bus.data_req   = 1'b1;
    bus.data_wen   = 4'b0011;
    bus.data_addr  = 32'h0000_2004;
    bus.data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (bus.data_addr_ok !== 1'b1 || bus.sram_en !== 1'b1 || bus.sram_wen !== 4'b0011 ||
        bus.sram_wdata !== 32'hDEAD_BEEF || bus.sram_addr !== 32'h0000_2004) begin
      failures++;
      $display("FAIL store_sram got ok=%b en=%b wen=%b wdata=%h addr=%h exp 1/1/0011/deadbeef/00002004",
               bus.data_addr_ok, bus.sram_en, bus.sram_wen, bus.sram_wdata, bus.sram_addr);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.data_data_ok !== 1'b1 || bus.inst_data_ok !== 1'b0) begin
      failures++;
      $display("FAIL store_resp got dok=%b iok=%b exp 1/0", bus.data_data_ok, bus.inst_data_ok);
    end
    $display("txn store addr=00002004 wen=0011 wdata=deadbeef");
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_3000;
    @(negedge clk);
    checks++;
    if (bus.data_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL b2b_grant0 got %b exp 1", bus.data_addr_ok);
    end
    next_cycle();
    bus.data_addr = 32'h0000_2004;
    @(negedge clk);
    checks++;
    if (bus.data_addr_ok !== 1'b1 || bus.data_data_ok !== 1'b1 || bus.data_rdata !== 32'h1111_2222) begin
      failures++;
      $display("FAIL b2b_overlap got aok=%b dok=%b rdata=%h exp 1/1/11112222", bus.data_addr_ok,
               bus.data_data_ok, bus.data_rdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.data_data_ok !== 1'b1 || bus.data_rdata !== 32'h0102_BEEF) begin
      failures++;
      $display("FAIL b2b_merged_load got dok=%b rdata=%h exp 1/0102beef", bus.data_data_ok, bus.data_rdata);
    end
    $display("txn back-to-back loads 00003000, 00002004 rdata=%h", bus.data_rdata);
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp_inst [8];
    exp_inst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_1000;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_3000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus.inst_addr_ok !== exp_inst[c] || bus.data_addr_ok !== !exp_inst[c]) begin
        failures++;
        $display("FAIL starve_grant cycle=%0d got i=%b d=%b exp i=%b d=%b", c, bus.inst_addr_ok,
                 bus.data_addr_ok, exp_inst[c], !exp_inst[c]);
      end
      if (c == 5) begin
        checks++;
        if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== 32'h2402_0001) begin
          failures++;
          $display("FAIL starve_inst_resp got ok=%b rdata=%h exp 1/24020001", bus.inst_data_ok, bus.inst_rdata);
        end
      end
      next_cycle();
    end
    idle_inputs();
    $display("txn starvation: 8 cycles contended, grants D,D,D,D,I,D,D,D");
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_3000;
    @(negedge clk);
    checks++;
    if (bus.data_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL midrst_grant got %b exp 1", bus.data_addr_ok);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.data_data_ok !== 1'b0 || bus.data_addr_ok !== 1'b0 || bus.sram_en !== 1'b0) begin
      failures++;
      $display("FAIL midrst_in_reset got dok=%b aok=%b en=%b exp 0/0/0", bus.data_data_ok,
               bus.data_addr_ok, bus.sram_en);
    end
    next_cycle();
    rst           = 1'b0;
    bus.data_req  = 1'b0;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_1000;
    @(negedge clk);
    checks++;
    if (bus.data_data_ok !== 1'b0 || bus.inst_data_ok !== 1'b0) begin
      failures++;
      $display("FAIL midrst_discard got dok=%b iok=%b exp 0/0", bus.data_data_ok, bus.inst_data_ok);
    end
    checks++;
    if (bus.inst_addr_ok !== 1'b1 || bus.sram_addr !== 32'h0000_1000) begin
      failures++;
      $display("FAIL midrst_resume got ok=%b addr=%h exp 1/00001000", bus.inst_addr_ok, bus.sram_addr);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== 32'h2402_0001) begin
      failures++;
      $display("FAIL midrst_fetch_resp got ok=%b rdata=%h exp 1/24020001", bus.inst_data_ok, bus.inst_rdata);
    end
    $display("txn reset mid-op: pending load dropped, fetch serviced after release");
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_back_to_back();
    test_starvation();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
